// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph table and helpers for display readback logic.
package seg7_pkg;

   typedef logic [6:0] seg7_pat_t;
   typedef logic [3:0] nibble_t;

   typedef enum logic {
      ACQ  = 1'b0,
      HOLD = 1'b1
   } seg7_cap_state_t;

   // Active-high segment patterns in {g,f,e,d,c,b,a} order, indexed by nibble value.
   localparam seg7_pat_t SEG7_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic seg7_is_onehot(input logic [7:0] v);
      return ($countones(v) == 1);
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational reverse lookup of a seven-segment pattern to its hex nibble.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  seg7_pat_t pat,
   output nibble_t   nibble_c,
   output logic      err_c
);

   // Unknown patterns decode to zero and raise err_c.
   always_comb begin
      nibble_c = '0;
      err_c    = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (pat == SEG7_GLYPH[i]) begin
            nibble_c = 4'(i);
            err_c    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Samples a multiplexed seven-segment bus, filters glitches and rebuilds the displayed word.
// Define SEG7_DP_EN to also capture the decimal point per digit (dp_n / out_dp).
module seg7_capture_decoder
   import seg7_pkg::*;
#(
   parameter int unsigned NUM_DIGITS    = 4,
   parameter int unsigned STABLE_CYCLES = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [6:0]                seg_n,
   input  logic [NUM_DIGITS-1:0]     dig_sel,
`ifdef SEG7_DP_EN
   input  logic                      dp_n,
   output logic [NUM_DIGITS-1:0]     out_dp,
`endif
   output logic [4*NUM_DIGITS-1:0]   out_word,
   output logic [NUM_DIGITS-1:0]     out_err,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      overflow,
   input  logic                      clr_overflow
);

   localparam int unsigned WW = 4 * NUM_DIGITS;
   localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
`ifdef SEG7_DP_EN
   localparam int unsigned SW = 8;
`else
   localparam int unsigned SW = 7;
`endif

   logic [SW-1:0]         seg_raw_c;
   logic [SW-1:0]         seg_s1, seg_s2, seg_prev;
   logic [NUM_DIGITS-1:0] dig_s1, dig_s2, dig_prev;
   logic [CW-1:0]         cnt, cnt_nxt_c;
   logic [NUM_DIGITS-1:0] mask;
   logic [WW-1:0]         stage_word;
   logic [NUM_DIGITS-1:0] stage_err;
   seg7_cap_state_t       state;

   seg7_pat_t pat_c;
   nibble_t   nib_c;
   logic      err_c;
   logic      changed_c, onehot_c, capture_c, frame_done_c, hs_c;

`ifdef SEG7_DP_EN
   logic [NUM_DIGITS-1:0] stage_dp;
   assign seg_raw_c = {dp_n, seg_n};
`else
   assign seg_raw_c = seg_n;
`endif

   assign pat_c        = seg7_pat_t'(~seg_s2[6:0]);
   assign changed_c    = ({seg_s2, dig_s2} != {seg_prev, dig_prev});
   assign onehot_c     = seg7_is_onehot(8'(dig_s2));
   assign frame_done_c = &mask;
   assign hs_c         = out_valid && out_ready;

   seg7_pattern_decode u_dec (
      .pat      (pat_c),
      .nibble_c (nib_c),
      .err_c    (err_c)
   );

   // Stability counter: restart on change, park at zero on a bad select, saturate at the threshold.
   always_comb begin
      cnt_nxt_c = cnt;
      if (!onehot_c)
         cnt_nxt_c = '0;
      else if (changed_c)
         cnt_nxt_c = CW'(1);
      else if (cnt != CW'(STABLE_CYCLES))
         cnt_nxt_c = cnt + CW'(1);
   end

   assign capture_c = onehot_c && (cnt_nxt_c == CW'(STABLE_CYCLES)) &&
                      (changed_c || (cnt != CW'(STABLE_CYCLES)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1     <= '0;
         seg_s2     <= '0;
         seg_prev   <= '0;
         dig_s1     <= '0;
         dig_s2     <= '0;
         dig_prev   <= '0;
         cnt        <= '0;
         mask       <= '0;
         stage_word <= '0;
         stage_err  <= '0;
`ifdef SEG7_DP_EN
         stage_dp   <= '0;
         out_dp     <= '0;
`endif
         out_word   <= '0;
         out_err    <= '0;
         out_valid  <= 1'b0;
         overflow   <= 1'b0;
         state      <= ACQ;
      end else begin
         seg_s1   <= seg_raw_c;
         seg_s2   <= seg_s1;
         seg_prev <= seg_s2;
         dig_s1   <= dig_sel;
         dig_s2   <= dig_s1;
         dig_prev <= dig_s2;
         cnt      <= cnt_nxt_c;

         // A capture landing on the completion edge starts the next frame's mask.
         mask <= (frame_done_c ? '0 : mask) | (capture_c ? dig_s2 : '0);
         for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (capture_c && dig_s2[i]) begin
               stage_word[4*i +: 4] <= nib_c;
               stage_err[i]         <= err_c;
`ifdef SEG7_DP_EN
               stage_dp[i]          <= ~seg_s2[7];
`endif
            end
         end

         if (clr_overflow)
            overflow <= 1'b0;

         // Later assignments win, so a drop in the same cycle as a clear keeps overflow set.
         case (state)
            ACQ: begin
               if (frame_done_c) begin
                  out_word  <= stage_word;
                  out_err   <= stage_err;
`ifdef SEG7_DP_EN
                  out_dp    <= stage_dp;
`endif
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (frame_done_c) begin
                  if (hs_c) begin
                     out_word <= stage_word;
                     out_err  <= stage_err;
`ifdef SEG7_DP_EN
                     out_dp   <= stage_dp;
`endif
                  end else begin
                     overflow <= 1'b1;
                  end
               end else if (hs_c) begin
                  out_valid <= 1'b0;
                  state     <= ACQ;
               end
            end
            default: state <= ACQ;
         endcase
      end
   end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder with a frame scoreboard checked at each handshake.
module tb_seg7_capture_decoder;

   localparam int ND = 4;
   localparam int SC = 8;
   localparam int HOLD_CYC = 12;

   typedef struct packed {
      logic [15:0] word;
      logic [3:0]  err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [6:0]    seg_n;
   logic [ND-1:0] dig_sel;
   logic [15:0]   out_word;
   logic [ND-1:0] out_err;
   logic          out_valid;
   logic          out_ready;
   logic          overflow;
   logic          clr_overflow;
`ifdef SEG7_DP_EN
   logic          dp_n = 1'b1;
   logic [ND-1:0] out_dp;
`endif

   logic [6:0] glyph [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h67, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
   };

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   seg7_capture_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_n        (seg_n),
      .dig_sel      (dig_sel),
`ifdef SEG7_DP_EN
      .dp_n         (dp_n),
      .out_dp       (out_dp),
`endif
      .out_word     (out_word),
      .out_err      (out_err),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard pop on every accepted frame.
   task automatic monitor();
      exp_t e;
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         n_chk++;
         assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_frame: observed word 0x%0h err 0x%0h, expected no frame",
                   out_word, out_err);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("frame_word", 32'(out_word), 32'(e.word));
            chk("frame_err", 32'(out_err), 32'(e.err));
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_pat(input int d, input logic [6:0] pat, input int n);
      dig_sel = ND'(1) << d;
      seg_n   = ~pat;
      repeat (n) step();
   endtask

   task automatic drive_nib(input int d, input logic [3:0] nib, input int n);
      drive_pat(d, glyph[nib], n);
   endtask

   task automatic idle(input int n);
      dig_sel = '0;
      seg_n   = 7'h7F;
      repeat (n) step();
   endtask

   task automatic send_frame(input logic [15:0] w);
      for (int d = 0; d < ND; d++)
         drive_nib(d, w[4*d +: 4], HOLD_CYC);
      idle(3);
   endtask

   initial begin
      rst_n        = 1'b0;
      out_ready    = 1'b1;
      clr_overflow = 1'b0;
      seg_n        = 7'h7F;
      dig_sel      = '0;
      #1;

      // Reset holds every output low regardless of inputs.
      for (int i = 0; i < 4; i++) begin
         seg_n     = 7'($urandom);
         dig_sel   = ND'($urandom);
         out_ready = 1'($urandom);
         step();
         chk("rst_word", 32'(out_word), 32'h0);
         chk("rst_err", 32'(out_err), 32'h0);
         chk("rst_valid", 32'(out_valid), 32'h0);
         chk("rst_overflow", 32'(overflow), 32'h0);
      end
      out_ready = 1'b1;
      dig_sel   = '0;
      seg_n     = 7'h7F;
      rst_n     = 1'b1;
      idle(20);
      chk("idle_valid", 32'(out_valid), 32'h0);

      // Basic frame decode.
      q.push_back('{word: 16'h1A2C, err: 4'h0});
      send_frame(16'h1A2C);
      chk("frame1_consumed", 32'(q.size()), 32'h0);
      chk("frame1_valid_low", 32'(out_valid), 32'h0);

      // Short hold and non-one-hot select must not capture digit 0.
      drive_pat(0, 7'h4F, SC - 1);
      dig_sel = 4'b0011;
      seg_n   = ~7'h06;
      repeat (20) step();
      drive_nib(1, 4'h5, HOLD_CYC);
      drive_nib(2, 4'h6, HOLD_CYC);
      drive_nib(3, 4'h7, HOLD_CYC);
      idle(3);
      chk("glitch_no_frame", 32'(out_valid), 32'h0);
      q.push_back('{word: 16'h7650, err: 4'h0});
      drive_pat(0, 7'h3F, 10);
      idle(4);
      chk("glitch_frame_consumed", 32'(q.size()), 32'h0);

      // Blank digit decodes as an error with nibble zero.
      q.push_back('{word: 16'h8903, err: 4'b0010});
      drive_nib(0, 4'h3, HOLD_CYC);
      drive_pat(1, 7'h00, HOLD_CYC);
      drive_nib(2, 4'h9, HOLD_CYC);
      drive_nib(3, 4'h8, HOLD_CYC);
      idle(3);
      chk("invalid_consumed", 32'(q.size()), 32'h0);

      // Backpressure: second frame dropped, third lands on the handshake edge.
      out_ready = 1'b0;
      q.push_back('{word: 16'h1234, err: 4'h0});
      send_frame(16'h1234);
      chk("bp_valid", 32'(out_valid), 32'h1);
      chk("bp_word1", 32'(out_word), 32'h1234);
      chk("bp_no_overflow", 32'(overflow), 32'h0);
      send_frame(16'h5678);
      chk("bp_word_held", 32'(out_word), 32'h1234);
      chk("bp_overflow", 32'(overflow), 32'h1);
      chk("bp_valid_held", 32'(out_valid), 32'h1);
      q.push_back('{word: 16'h9ABC, err: 4'h0});
      drive_nib(0, 4'hC, HOLD_CYC);
      drive_nib(1, 4'hB, HOLD_CYC);
      drive_nib(2, 4'hA, HOLD_CYC);
      drive_nib(3, 4'h9, SC + 2);
      chk("bp_word_before_load", 32'(out_word), 32'h1234);
      out_ready = 1'b1;
      step();
      chk("bp_simul_valid", 32'(out_valid), 32'h1);
      chk("bp_simul_word", 32'(out_word), 32'h9ABC);
      step();
      chk("bp_after_accept_valid", 32'(out_valid), 32'h0);
      chk("bp_queue_empty", 32'(q.size()), 32'h0);
      idle(3);
      chk("overflow_sticky", 32'(overflow), 32'h1);
      clr_overflow = 1'b1;
      step();
      clr_overflow = 1'b0;
      chk("overflow_cleared", 32'(overflow), 32'h0);

      // Reset mid-frame discards the partial frame.
      drive_nib(0, 4'h3, HOLD_CYC);
      drive_nib(1, 4'h4, HOLD_CYC);
      dig_sel = '0;
      seg_n   = 7'h7F;
      rst_n   = 1'b0;
      step();
      chk("midrst_word", 32'(out_word), 32'h0);
      chk("midrst_valid", 32'(out_valid), 32'h0);
      rst_n = 1'b1;
      idle(2);
      drive_nib(2, 4'h6, HOLD_CYC);
      drive_nib(3, 4'h5, HOLD_CYC);
      idle(3);
      chk("midrst_partial_no_frame", 32'(out_valid), 32'h0);
      q.push_back('{word: 16'h5621, err: 4'h0});
      drive_nib(0, 4'h1, HOLD_CYC);
      drive_nib(1, 4'h2, HOLD_CYC);
      idle(4);
      chk("midrst_frame_consumed", 32'(q.size()), 32'h0);
      chk("final_valid_low", 32'(out_valid), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
